// File: rtl/retire_stage.sv
// In-order retire stage: commits completed ROB heads to the map table and free list,
// turns head exceptions into a timed interrupt/flush, and sticks in HALTED after a halt.
module retire_stage #(
    parameter int FLUSH_CYCLES = 2,
    parameter int CNT_W        = 32,
    parameter int TAG_W        = 6
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               rob_head_valid,
    input  logic               rob_head_complete,
    input  logic               rob_head_exception,
    input  logic               rob_head_halt,
    input  logic [TAG_W-1:0]   rob_head_t,
    input  logic [TAG_W-1:0]   rob_head_t_old,
    output logic               rob_retire_ack,
    output logic [2*TAG_W:0]   ir_mt_packet,
    output logic               fl_free_en,
    output logic [TAG_W-1:0]   fl_free_tag,
    output logic               interrupt,
    output logic [CNT_W-1:0]   retire_count,
    output logic               halted,
    output logic [1:0]         state_dbg
);

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_FLUSH  = 2'd1,
        ST_HALTED = 2'd2
    } state_t;

    state_t     state_q;
    state_t     state_d;
    logic [3:0] flush_cnt_q;
    logic       head_ready;
    logic       retire_go;
    logic       take_exc;

    // Handshake: the ROB offers its head through rob_head_valid (and complete); this stage
    // pops it by raising rob_retire_ack in the same cycle, and the ROB advances its head
    // on the following rising edge. Ack never depends on any registered output.
    assign head_ready = rob_head_valid & rob_head_complete;
    assign retire_go  = (state_q == ST_RUN) & head_ready & ~rob_head_exception;
    assign take_exc   = (state_q == ST_RUN) & head_ready &  rob_head_exception;
    assign state_dbg  = state_q;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= ST_RUN;
        end else begin
            state_q <= state_d;
        end
    end

    // Exception outranks halt, so an excepting halt flushes instead of halting.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_RUN: begin
                if (take_exc) begin
                    state_d = ST_FLUSH;
                end else if (retire_go && rob_head_halt) begin
                    state_d = ST_HALTED;
                end
            end
            ST_FLUSH: begin
                if (flush_cnt_q == 4'd0) begin
                    state_d = ST_RUN;
                end
            end
            ST_HALTED: state_d = ST_HALTED;
            default:   state_d = ST_RUN;
        endcase
    end

    always_comb begin
        rob_retire_ack = 1'b0;
        if (state_q == ST_RUN) begin
            rob_retire_ack = retire_go;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            flush_cnt_q <= 4'd0;
        end else if (take_exc) begin
            flush_cnt_q <= 4'(FLUSH_CYCLES - 1);
        end else if (state_q == ST_FLUSH && flush_cnt_q != 4'd0) begin
            flush_cnt_q <= flush_cnt_q - 4'd1;
        end
    end

    // Retire outputs are one-cycle pulses and fall back to zero whenever nothing retires.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            ir_mt_packet <= '0;
            fl_free_en   <= 1'b0;
            fl_free_tag  <= '0;
            interrupt    <= 1'b0;
            retire_count <= '0;
            halted       <= 1'b0;
        end else begin
            ir_mt_packet <= retire_go ? {1'b1, rob_head_t, rob_head_t_old} : '0;
            fl_free_en   <= retire_go && (rob_head_t_old != '0);
            fl_free_tag  <= (retire_go && (rob_head_t_old != '0)) ? rob_head_t_old : '0;
            interrupt    <= (state_d == ST_FLUSH);
            halted       <= (state_d == ST_HALTED);
            if (retire_go) begin
                retire_count <= retire_count + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_retire_stage.sv
// Randomized and directed bench for retire_stage against a cycle-indexed reference model.
module tb_retire_stage;

  localparam int F     = 2;
  localparam int TAG_W = 6;
  localparam int CNT_W = 32;

  logic               clock;
  logic               reset;
  logic               rob_head_valid;
  logic               rob_head_complete;
  logic               rob_head_exception;
  logic               rob_head_halt;
  logic [TAG_W-1:0]   rob_head_t;
  logic [TAG_W-1:0]   rob_head_t_old;
  logic               rob_retire_ack;
  logic [2*TAG_W:0]   ir_mt_packet;
  logic               fl_free_en;
  logic [TAG_W-1:0]   fl_free_tag;
  logic               interrupt;
  logic [CNT_W-1:0]   retire_count;
  logic               halted;
  logic [1:0]         state_dbg;

  retire_stage #(.FLUSH_CYCLES(F), .CNT_W(CNT_W), .TAG_W(TAG_W)) dut (
    .clock              (clock),
    .reset              (reset),
    .rob_head_valid     (rob_head_valid),
    .rob_head_complete  (rob_head_complete),
    .rob_head_exception (rob_head_exception),
    .rob_head_halt      (rob_head_halt),
    .rob_head_t         (rob_head_t),
    .rob_head_t_old     (rob_head_t_old),
    .rob_retire_ack     (rob_retire_ack),
    .ir_mt_packet       (ir_mt_packet),
    .fl_free_en         (fl_free_en),
    .fl_free_tag        (fl_free_tag),
    .interrupt          (interrupt),
    .retire_count       (retire_count),
    .halted             (halted),
    .state_dbg          (state_dbg)
  );

  // clock / reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  int total;
  int bad;

  // reference model: interrupt covers cycles exc+1 .. exc+F, retire blocked until flush_end
  int          cyc;
  int          flush_end;
  bit          halted_m;
  logic [31:0] count_m;
  int          halted_age;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic model_reset();
    flush_end  = 0;
    halted_m   = 1'b0;
    count_m    = '0;
    halted_age = 0;
  endtask

  task automatic check_cleared(input string tag);
    check({tag, "_retire_en"}, 64'(ir_mt_packet), 64'd0);
    check({tag, "_free_en"}, 64'(fl_free_en), 64'd0);
    check({tag, "_interrupt"}, 64'(interrupt), 64'd0);
    check({tag, "_count"}, 64'(retire_count), 64'd0);
    check({tag, "_halted"}, 64'(halted), 64'd0);
  endtask

  // async assert at a falling edge, release at a later falling edge
  task automatic apply_reset();
    @(negedge clock);
    rob_head_valid = 1'b0;
    rob_head_complete = 1'b0;
    rob_head_exception = 1'b0;
    rob_head_halt = 1'b0;
    reset = 1'b0;
    #1;
    check_cleared("reset");
    model_reset();
    @(negedge clock);
    reset = 1'b1;
  endtask

  // driver + scoreboard for one clock cycle
  task automatic cycle(input bit v, input bit c, input bit e, input bit h,
                       input logic [TAG_W-1:0] t, input logic [TAG_W-1:0] t_old);
    bit exp_ack;
    bit blocked;
    @(negedge clock);
    rob_head_valid     = v;
    rob_head_complete  = c;
    rob_head_exception = e;
    rob_head_halt      = h;
    rob_head_t         = t;
    rob_head_t_old     = t_old;
    #1;
    blocked = halted_m || (cyc < flush_end);
    exp_ack = !blocked && v && c && !e;
    check("ack", 64'(rob_retire_ack), 64'(exp_ack));
    if (!blocked && v && c && e) flush_end = cyc + F + 1;
    if (exp_ack) begin
      count_m++;
      if (h) halted_m = 1'b1;
    end
    @(posedge clock);
    #1;
    cyc++;
    check("retire_en", 64'(ir_mt_packet[2*TAG_W]), 64'(exp_ack));
    check("retire_t", 64'(ir_mt_packet[2*TAG_W-1:TAG_W]), exp_ack ? 64'(t) : 64'd0);
    check("retire_t_old", 64'(ir_mt_packet[TAG_W-1:0]), exp_ack ? 64'(t_old) : 64'd0);
    check("free_en", 64'(fl_free_en), 64'(exp_ack && t_old != 0));
    check("free_tag", 64'(fl_free_tag), (exp_ack && t_old != 0) ? 64'(t_old) : 64'd0);
    check("interrupt", 64'(interrupt), 64'(cyc < flush_end));
    check("count", 64'(retire_count), 64'(count_m));
    check("halted", 64'(halted), 64'(halted_m));
  endtask

  initial begin
    total = 0;
    bad   = 0;
    cyc   = 0;
    model_reset();
    reset = 1'b1;
    rob_head_valid = 1'b0;
    rob_head_complete = 1'b0;
    rob_head_exception = 1'b0;
    rob_head_halt = 1'b0;
    rob_head_t = '0;
    rob_head_t_old = '0;
    apply_reset();

    // single retire P33/P5, then idle
    cycle(1, 1, 0, 0, 6'd33, 6'd5);
    cycle(0, 0, 0, 0, 6'd0, 6'd0);
    // back-to-back retires, one with t_old = P0
    cycle(1, 1, 0, 0, 6'd40, 6'd7);
    cycle(1, 1, 0, 0, 6'd41, 6'd0);
    cycle(1, 1, 0, 0, 6'd42, 6'd9);
    cycle(1, 1, 0, 0, 6'd43, 6'd11);
    // head waits for completion
    for (int i = 0; i < 3; i++) cycle(1, 0, 0, 0, 6'd20, 6'd21);
    cycle(1, 1, 0, 0, 6'd20, 6'd21);
    // exception, then a completed head held through the flush
    cycle(1, 1, 1, 0, 6'd50, 6'd51);
    for (int i = 0; i < F + 1; i++) cycle(1, 1, 0, 0, 6'd52, 6'd53);
    // exception + halt flushes rather than halting
    cycle(1, 1, 1, 1, 6'd54, 6'd55);
    for (int i = 0; i < F + 1; i++) cycle(0, 0, 0, 0, 6'd0, 6'd0);
    // halt retires, then nothing else is acked
    cycle(1, 1, 0, 1, 6'd60, 6'd61);
    for (int i = 0; i < 3; i++) cycle(1, 1, 0, 0, 6'd62, 6'd63);
    cycle(1, 1, 1, 0, 6'd62, 6'd63);

    // reset during the second flush cycle
    apply_reset();
    cycle(1, 1, 0, 0, 6'd10, 6'd12);
    cycle(1, 1, 1, 0, 6'd13, 6'd14);
    cycle(0, 0, 0, 0, 6'd0, 6'd0);
    apply_reset();
    cycle(1, 1, 0, 0, 6'd15, 6'd16);

    // randomized traffic
    for (int n = 0; n < 3000; n++) begin
      if ((halted_m && halted_age > 4) || $urandom_range(0, 399) == 0) begin
        apply_reset();
      end else begin
        cycle($urandom_range(0, 9) < 8, $urandom_range(0, 9) < 7,
              $urandom_range(0, 9) == 0, $urandom_range(0, 29) == 0,
              TAG_W'($urandom_range(0, 63)),
              ($urandom_range(0, 7) == 0) ? 6'd0 : TAG_W'($urandom_range(0, 63)));
        if (halted_m) halted_age++;
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
